// File: rtl/mc_pipe_reg_if.sv
// Handshake bundle for mc_pipe_reg: upstream valid/ready, downstream valid/ready, flush and status.
// The master side drives the inputs of the chain. The slave side is the chain itself.
interface mc_pipe_reg_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic             parity_err;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, parity_err
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, parity_err
    );
endinterface

// File: rtl/mc_pipe_reg.sv
// Elastic DEPTH-stage valid/ready register chain with bubble collapsing, flush and occupancy count.
// Optional MC_PIPE_REG_PARITY_EN carries an even-parity bit per stage and flags mismatches at the output.
module mc_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    mc_pipe_reg_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("mc_pipe_reg: DEPTH must be >= 1");
        end
    endgenerate

    logic [DEPTH-1:0]            v_q, v_d, mv, ld;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        in_xfer, out_xfer;
`ifdef MC_PIPE_REG_PARITY_EN
    logic [DEPTH-1:0]            par_q, par_d;
`endif

    // A stage may advance if it or any stage downstream of it is empty, or the sink drains.
    for (genvar i = 0; i < DEPTH; i++) begin : g_mv
        assign mv[i] = bus.out_ready | ~(&v_q[DEPTH-1:i]);
    end

    assign bus.in_ready = mv[0] & ~bus.flush;
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign out_xfer     = v_q[DEPTH-1] & bus.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        if (i == 0) begin : g_head
            assign src_v = bus.in_valid;
            assign src_d = bus.in_data;
        end else begin : g_body
            assign src_v = v_q[i-1];
            assign src_d = data_q[i-1];
        end
        // Data only loads real words so a bubble never overwrites the last held value.
        assign ld[i]     = mv[i] & src_v & ~bus.flush;
        assign v_d[i]    = bus.flush ? 1'b0 : (mv[i] ? src_v : v_q[i]);
        assign data_d[i] = ld[i] ? src_d : data_q[i];
`ifdef MC_PIPE_REG_PARITY_EN
        if (i == 0) begin : g_par_head
            assign par_d[i] = ld[i] ? ^bus.in_data : par_q[i];
        end else begin : g_par_body
            assign par_d[i] = ld[i] ? par_q[i-1] : par_q[i];
        end
`endif
    end

    assign count_d = bus.flush ? '0 : count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

`ifdef MC_PIPE_REG_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_q <= '0;
        else       par_q <= par_d;
    end
    assign bus.parity_err = v_q[DEPTH-1] & ((^data_q[DEPTH-1]) != par_q[DEPTH-1]);
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_mc_pipe_reg.sv
// Drives a DEPTH=2 and a DEPTH=3 chain with the same stimulus and checks both against a token/position model.
module tb_mc_pipe_reg;
    logic        clk;
    logic        reset;
    logic        iv, ordy, fl;
    logic [31:0] id;
    int          errs = 0;
    int          checks = 0;

    mc_pipe_reg_if #(.WIDTH(32), .DEPTH(2)) b2 ();
    mc_pipe_reg_if #(.WIDTH(32), .DEPTH(3)) b3 ();

    assign b2.in_valid = iv;  assign b3.in_valid = iv;
    assign b2.in_data = id;   assign b3.in_data = id;
    assign b2.out_ready = ordy; assign b3.out_ready = ordy;
    assign b2.flush = fl;     assign b3.flush = fl;

    mc_pipe_reg #(.WIDTH(32), .DEPTH(2)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
    mc_pipe_reg #(.WIDTH(32), .DEPTH(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: each chain holds tokens (oldest first), each with its stage position.
    int          mn[2];
    int          mp[2][4];
    logic [31:0] md[2][4];

    always @(negedge clk) begin
        int          dep, tn, lim, p;
        int          tpos[4];
        logic [31:0] tdat[4];
        logic        gir, gov, gpe, eov, eir;
        logic [31:0] god;
        int          gcn;
        for (int k = 0; k < 2; k++) begin
            dep = (k == 0) ? 2 : 3;
            gir = (k == 0) ? b2.in_ready  : b3.in_ready;
            gov = (k == 0) ? b2.out_valid : b3.out_valid;
            god = (k == 0) ? b2.out_data  : b3.out_data;
            gcn = (k == 0) ? int'(b2.count) : int'(b3.count);
            gpe = (k == 0) ? b2.parity_err : b3.parity_err;
            if (reset) begin
                chk($sformatf("d%0d rst out_valid", dep), 32'(gov), 32'd0);
                chk($sformatf("d%0d rst count", dep), 32'(gcn), 32'd0);
                chk($sformatf("d%0d rst out_data", dep), god, 32'd0);
                mn[k] = 0;
            end else begin
                eov = (mn[k] > 0) && (mp[k][0] == dep - 1);
                tn  = 0;
                lim = ordy ? dep + 1 : dep;
                for (int e = 0; e < mn[k]; e++) begin
                    p = mp[k][e];
                    if (p + 1 < lim) p++;
                    if (p < dep) begin
                        tdat[tn] = md[k][e];
                        tpos[tn] = p;
                        tn++;
                        lim = p;
                    end
                end
                eir = !fl && !((tn > 0) && (tpos[tn-1] == 0));
                chk($sformatf("d%0d in_ready", dep), 32'(gir), 32'(eir));
                chk($sformatf("d%0d out_valid", dep), 32'(gov), 32'(eov));
                chk($sformatf("d%0d count", dep), 32'(gcn), 32'(mn[k]));
                chk($sformatf("d%0d parity_err", dep), 32'(gpe), 32'd0);
                if (eov) chk($sformatf("d%0d out_data", dep), god, md[k][0]);
                if (fl) begin
                    mn[k] = 0;
                end else begin
                    for (int e = 0; e < tn; e++) begin
                        md[k][e] = tdat[e];
                        mp[k][e] = tpos[e];
                    end
                    mn[k] = tn;
                    if (iv && eir) begin
                        md[k][tn] = id;
                        mp[k][tn] = 0;
                        mn[k]     = tn + 1;
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; iv = 1'b0; ordy = 1'b0; fl = 1'b0; id = '0;
        mn[0] = 0; mn[1] = 0;
        #3;
        chk("init out_valid", 32'(b2.out_valid), 32'd0);
        chk("init count", 32'(b2.count), 32'd0);
        chk("init out_data", b2.out_data, 32'd0);
        cyc(); cyc();
        reset = 1'b0;

        // Latency: one word through each depth.
        ordy = 1'b1; iv = 1'b1; id = 32'hA5A5A5A5;
        cyc();
        iv = 1'b0; #1;
        chk("lat e1 d2 valid", 32'(b2.out_valid), 32'd0);
        chk("lat e1 d3 valid", 32'(b3.out_valid), 32'd0);
        cyc(); #1;
        chk("lat e2 d2 valid", 32'(b2.out_valid), 32'd1);
        chk("lat e2 d2 data", b2.out_data, 32'hA5A5A5A5);
        chk("lat e2 d3 valid", 32'(b3.out_valid), 32'd0);
        cyc(); #1;
        chk("lat e3 d2 valid", 32'(b2.out_valid), 32'd0);
        chk("lat e3 d3 valid", 32'(b3.out_valid), 32'd1);
        chk("lat e3 d3 data", b3.out_data, 32'hA5A5A5A5);
        cyc(); #1;
        chk("lat e4 d3 valid", 32'(b3.out_valid), 32'd0);

        // Async reset between edges while holding data.
        ordy = 1'b0; iv = 1'b1; id = 32'h11;
        cyc(); id = 32'h22;
        cyc(); iv = 1'b0; #1;
        chk("t1 d2 count full", 32'(b2.count), 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("t1 d2 out_valid", 32'(b2.out_valid), 32'd0);
        chk("t1 d2 count", 32'(b2.count), 32'd0);
        chk("t1 d2 out_data", b2.out_data, 32'd0);
        chk("t1 d3 count", 32'(b3.count), 32'd0);
        cyc(); reset = 1'b0;

        // Stall until full, then drain in order.
        ordy = 1'b0; iv = 1'b1; id = 32'h1;
        cyc(); id = 32'h2;
        cyc(); id = 32'h3; #1;
        chk("t3 d2 in_ready", 32'(b2.in_ready), 32'd0);
        chk("t3 d2 count", 32'(b2.count), 32'd2);
        cyc(); iv = 1'b0; ordy = 1'b1; #1;
        chk("t3 d2 first valid", 32'(b2.out_valid), 32'd1);
        chk("t3 d2 first data", b2.out_data, 32'h1);
        cyc(); #1;
        chk("t3 d2 second valid", 32'(b2.out_valid), 32'd1);
        chk("t3 d2 second data", b2.out_data, 32'h2);
        cyc(); #1;
        chk("t3 d2 drained", 32'(b2.out_valid), 32'd0);
        repeat (4) cyc();

        // Bubble collapse behind a stalled head.
        ordy = 1'b0; iv = 1'b1; id = 32'h1;
        cyc(); iv = 1'b0;
        cyc(); iv = 1'b1; id = 32'h2;
        cyc(); iv = 1'b0;
        cyc(); cyc(); #1;
        chk("t4 d3 count", 32'(b3.count), 32'd2);
        chk("t4 d3 head valid", 32'(b3.out_valid), 32'd1);
        chk("t4 d3 head data", b3.out_data, 32'h1);
        ordy = 1'b1;
        cyc(); #1;
        chk("t4 d3 next valid", 32'(b3.out_valid), 32'd1);
        chk("t4 d3 next data", b3.out_data, 32'h2);
        cyc(); #1;
        chk("t4 d3 drained", 32'(b3.out_valid), 32'd0);
        repeat (3) cyc();

        // Flush on a full chain with a word presented.
        ordy = 1'b0; iv = 1'b1; id = 32'h5;
        cyc(); id = 32'h6;
        cyc(); id = 32'h9; fl = 1'b1; #1;
        chk("t5 d2 in_ready", 32'(b2.in_ready), 32'd0);
        chk("t5 d2 count pre", 32'(b2.count), 32'd2);
        cyc(); fl = 1'b0; iv = 1'b0; #1;
        chk("t5 d2 count", 32'(b2.count), 32'd0);
        chk("t5 d2 out_valid", 32'(b2.out_valid), 32'd0);
        chk("t5 d3 count", 32'(b3.count), 32'd0);
        ordy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc(); #1;
            chk("t5 d2 no emerge", 32'(b2.out_valid), 32'd0);
            chk("t5 d3 no emerge", 32'(b3.out_valid), 32'd0);
        end

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 800; c++) begin
            cyc();
            reset = 1'b0;
            iv    = ($urandom_range(0, 3) != 0);
            id    = $urandom;
            ordy  = ($urandom_range(0, 2) != 0);
            fl    = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 150) == 0) reset = 1'b1;
        end
        cyc();
        reset = 1'b0; iv = 1'b0; fl = 1'b0; ordy = 1'b0;

`ifdef MC_PIPE_REG_PARITY_EN
        iv = 1'b1; id = 32'hFF;
        cyc(); iv = 1'b0;
        cyc(); #1;
        chk("t6 parity clean", 32'(b2.parity_err), 32'd0);
        @(negedge clk); #1;
        u2.data_q[1][0] = ~u2.data_q[1][0];
        #1;
        chk("t6 parity_err", 32'(b2.parity_err), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6 parity reset", 32'(b2.parity_err), 32'd0);
`endif

        cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
